ldst_write_buffer: RTL and testbench
====================================

// Module: ldst_write_buffer
// PURPOSE
// - Posted-write FIFO between the core load/store port and the downstream data/IO router.
// - Writes complete to the core one cycle after acceptance; the buffer drains them in the background.
// - Reads observe program order: they wait until all older buffered writes have drained,
//   then issue downstream.
// - Hides downstream write latency from the core; the halt logic uses wb_empty.
// PARAMETERS
// - DEPTH   4   FIFO entries; power of two, >= 2
// - ADDR_W  30  word-address width (ptr)
// - DATA_W  32  data width (word)
// PORTS
// - clk           in   1       single clock, all logic
// - rst           in   1       asynchronous, active-high reset
// - core_start    in   1       one-cycle request pulse; legal only when no request is pending
// - core_write    in   1       1 = store, 0 = load; sampled with core_start
// - core_addr     in   ADDR_W  request address; sampled with core_start
// - core_data_wr  in   DATA_W  store data; sampled with core_start
// - core_ready    out  1       one-cycle completion pulse
// - core_data_rd  out  DATA_W  load data; valid in the core_ready cycle of a load
// - mem_start     out  1       one-cycle downstream request pulse
// - mem_write     out  1       downstream direction; held stable until mem_ready
// - mem_addr      out  ADDR_W  held stable until mem_ready
// - mem_data_wr   out  DATA_W  held stable until mem_ready
// - mem_ready     in   1       one-cycle downstream completion pulse
// - mem_data_rd   in   DATA_W  downstream load data; valid with mem_ready
// - wb_empty      out  1       1 = FIFO empty and no downstream access outstanding
// BEHAVIOUR
// - Reset: every output 0 except wb_empty=1. FIFO pointers, count and pending request cleared.
//   State = IDLE. In-flight downstream accesses are abandoned.
// - FIFO: rd_ptr/wr_ptr are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
//   full = (count==DEPTH); empty = (count==0).
// - Store accepted: push {addr,data} into the FIFO. core_ready pulses on the next cycle.
// - Store while full: latch into the pending register. Push in the first cycle count<DEPTH
//   (including the cycle a pop frees a slot). core_ready pulses on the cycle after the push.
// - Load: latch into the pending register. It is issued downstream only when the FIFO is
//   empty and the drain engine is idle.
//   - core_data_rd <= mem_data_rd; core_ready pulses the cycle after mem_ready.
// - Drain/issue FSM: IDLE, WR_WAIT, RD_WAIT.
//   - IDLE with FIFO non-empty: present the head entry, mem_write=1, pulse mem_start.
//     Go to WR_WAIT.
//   - WR_WAIT: on mem_ready, pop the head and return to IDLE. A back-to-back drain starts
//     the following cycle.
//   - IDLE, FIFO empty, pending load: present the load, mem_write=0, pulse mem_start.
//     Go to RD_WAIT.
//   - RD_WAIT: on mem_ready, capture the data, clear the pending load, return to IDLE.
// - Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
// - Downstream outputs never change between mem_start and mem_ready.
//   mem_start never pulses while in WR_WAIT or RD_WAIT.
// - mem_ready while in IDLE is ignored.
// - core_start while a request is pending: protocol violation.
//   Ignored; an assertion fires in simulation.
// - wb_empty = empty && state==IDLE && no pending store. Combinational from registers.
// CONFIGURATION
// - WBUF_FORWARD_EN defined: a load whose address matches a valid FIFO entry completes
//   without draining.
//   - Uses the youngest matching entry.
//   - core_ready pulses one cycle after core_start, with that entry's data.
//   - Draining continues in the background; no downstream read is issued.
// - WBUF_FORWARD_EN undefined: no comparators. Every load waits for the full drain.
//   This is the default.
// TESTING
// - Reset mid-drain: rst during WR_WAIT -> next cycle all outputs 0, wb_empty=1, count=0.
//   A late mem_ready is ignored.
// - Posted stores: 4 stores (addr 0x10..0x13, data 0xA0..0xA3), mem_ready held off
//   -> four core_ready pulses, each 1 cycle after its start.
//   Release mem_ready -> mem writes appear in order 0x10..0x13.
// - Full FIFO: 5th store (0x14, 0xA4) while full -> no core_ready until the first mem_ready.
//   Then core_ready 2 cycles later; 0x14 is the 5th downstream write.
// - Load ordering: store (0x20, 0x55), then load 0x30 -> mem_start for the read only after
//   the write's mem_ready. Downstream read returns 0x1234 -> core_data_rd=0x1234.
// - Forwarding (WBUF_FORWARD_EN): stores (0x40, 0x11) then (0x40, 0x22), then load 0x40
//   -> core_ready 1 cycle later, data 0x22, no downstream read.
//   Without the macro: the read is issued after 2 writes drain.
// - Push/pop same cycle: FIFO at count=2, mem_ready coincides with a store
//   -> count stays 2, order preserved.

Source files
------------

// File: rtl/ldst_write_buffer.sv
// Posted-write buffer between the core load/store port and the downstream router.
// Optional store-to-load forwarding is enabled by defining WBUF_FORWARD_EN.
module ldst_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_start,
    input  logic              core_write,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_data_wr,
    output logic              core_ready,
    output logic [DATA_W-1:0] core_data_rd,
    output logic              mem_start,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_wr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data_rd,
    output logic              wb_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;
    state_t state_reg, state_next;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              pend_valid_reg, pend_write_reg;
    logic [ADDR_W-1:0] pend_addr_reg;
    logic [DATA_W-1:0] pend_data_reg;
    logic              core_ready_reg;
    logic [DATA_W-1:0] core_data_rd_reg;

    logic              full, empty, accept, direct_push, pend_push, push, pop, rd_done;
    logic [ADDR_W-1:0] push_addr, head_addr;
    logic [DATA_W-1:0] push_data, head_data;
    logic              fwd_load;
    logic [DATA_W-1:0] fwd_data;

    assign full        = (count_reg == FULL_COUNT);
    assign empty       = (count_reg == '0);
    assign accept      = core_start && !pend_valid_reg;
    assign direct_push = accept && core_write && !full;
    // A store parked while full enters as soon as the registered count shows a free slot.
    assign pend_push   = pend_valid_reg && pend_write_reg && !full;
    assign push        = direct_push || pend_push;
    assign push_addr   = pend_push ? pend_addr_reg : core_addr;
    assign push_data   = pend_push ? pend_data_reg : core_data_wr;
    assign pop         = (state_reg == WR_WAIT) && mem_ready;
    assign rd_done     = (state_reg == RD_WAIT) && mem_ready;
    assign head_addr   = addr_mem[rd_ptr_reg];
    assign head_data   = data_mem[rd_ptr_reg];

`ifdef WBUF_FORWARD_EN
    logic [DEPTH-1:0] fwd_match;
    logic             fwd_hit;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
        logic [PTR_W-1:0] slot;
        assign slot          = rd_ptr_reg + PTR_W'(gi);
        assign fwd_match[gi] = (CNT_W'(gi) < count_reg) && (addr_mem[slot] == core_addr);
    end

    // Offsets grow from oldest to youngest, so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fwd_match[i]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[rd_ptr_reg + PTR_W'(i)];
            end
        end
    end

    assign fwd_load = accept && !core_write && fwd_hit;
`else
    assign fwd_load = 1'b0;
    assign fwd_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= push_addr;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            count_reg        <= '0;
            pend_valid_reg   <= 1'b0;
            pend_write_reg   <= 1'b0;
            pend_addr_reg    <= '0;
            pend_data_reg    <= '0;
            core_ready_reg   <= 1'b0;
            core_data_rd_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (accept && !direct_push && !fwd_load) begin
                pend_valid_reg <= 1'b1;
                pend_write_reg <= core_write;
                pend_addr_reg  <= core_addr;
                pend_data_reg  <= core_data_wr;
            end else if (pend_push || rd_done) begin
                pend_valid_reg <= 1'b0;
            end
            core_ready_reg <= push || rd_done || fwd_load;
            if (rd_done) begin
                core_data_rd_reg <= mem_data_rd;
            end else if (fwd_load) begin
                core_data_rd_reg <= fwd_data;
            end
        end
    end

    // Downstream fields come only from the head entry or the parked load, both frozen while waiting.
    always_comb begin
        state_next  = state_reg;
        mem_start   = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_data_wr = '0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    mem_start   = 1'b1;
                    mem_write   = 1'b1;
                    mem_addr    = head_addr;
                    mem_data_wr = head_data;
                    state_next  = WR_WAIT;
                end else if (pend_valid_reg && !pend_write_reg) begin
                    mem_start  = 1'b1;
                    mem_addr   = pend_addr_reg;
                    state_next = RD_WAIT;
                end
            end
            WR_WAIT: begin
                mem_write   = 1'b1;
                mem_addr    = head_addr;
                mem_data_wr = head_data;
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            RD_WAIT: begin
                mem_addr = pend_addr_reg;
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign core_ready   = core_ready_reg;
    assign core_data_rd = core_data_rd_reg;
    assign wb_empty     = empty && (state_reg == IDLE) && !(pend_valid_reg && pend_write_reg);

    core_start_when_pending: assert property (@(posedge clk) disable iff (rst)
        !(core_start && pend_valid_reg));

endmodule

// File: tb/tb_ldst_write_buffer.sv
// Bench for ldst_write_buffer: directed scenarios plus random traffic against a
// program-order memory model and an in-order downstream write scoreboard.
module tb_ldst_write_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    logic              clk, rst;
    logic              core_start, core_write;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_data_wr;
    logic              core_ready;
    logic [DATA_W-1:0] core_data_rd;
    logic              mem_start, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_wr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_data_rd;
    logic              wb_empty;

    ldst_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .core_start(core_start), .core_write(core_write), .core_addr(core_addr),
        .core_data_wr(core_data_wr), .core_ready(core_ready), .core_data_rd(core_data_rd),
        .mem_start(mem_start), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data_wr(mem_data_wr), .mem_ready(mem_ready), .mem_data_rd(mem_data_rd),
        .wb_empty(wb_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               wq[$];          // stores accepted by the core, not yet written downstream
    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] dmem    [logic [ADDR_W-1:0]];
    int                n_checks = 0;
    int                n_fail   = 0;
    bit                hold = 1'b0, abandon = 1'b0, just_done = 1'b0;
    logic [ADDR_W-1:0] jd_addr = '0;
    int                lat_max = 3, rd_issued = 0, late_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return {a, 2'b11} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Downstream responder: random latency, optional hold, in-order write scoreboard.
    initial begin
        bit                busy;
        int                cnt;
        logic              op_wr;
        logic [ADDR_W-1:0] op_addr;
        logic [DATA_W-1:0] op_data;
        wr_t               exp_w;
        busy = 1'b0; cnt = 0; op_wr = 1'b0; op_addr = '0; op_data = '0;
        mem_ready = 1'b0; mem_data_rd = '0;
        forever begin
            @(negedge clk);
            mem_ready   = 1'b0;
            mem_data_rd = $urandom;
            just_done   = 1'b0;
            if (rst) continue;
            if (busy) begin
                check("start_while_busy", mem_start, 1'b0);
                if (!abandon) begin
                    check("hold_write", mem_write, op_wr);
                    check("hold_addr", mem_addr, op_addr);
                    if (op_wr) check("hold_data", mem_data_wr, op_data);
                end
                if (cnt > 1) begin
                    cnt--;
                end else if (!hold) begin
                    mem_ready = 1'b1;
                    busy      = 1'b0;
                    if (abandon) begin
                        abandon = 1'b0;
                        late_cnt++;
                    end else if (op_wr) begin
                        check("wq_nonempty", wq.size() != 0, 1'b1);
                        if (wq.size() != 0) begin
                            exp_w = wq.pop_front();
                            check("wr_order_addr", op_addr, exp_w.addr);
                            check("wr_order_data", op_data, exp_w.data);
                        end
                        dmem[op_addr] = op_data;
                        just_done = 1'b1;
                        jd_addr   = op_addr;
                    end else begin
                        mem_data_rd = dmem.exists(op_addr) ? dmem[op_addr] : init_val(op_addr);
                    end
                end
            end else if (mem_start) begin
                busy    = 1'b1;
                cnt     = $urandom_range(1, lat_max);
                op_wr   = mem_write;
                op_addr = mem_addr;
                op_data = mem_data_wr;
                if (!op_wr) begin
                    rd_issued++;
                    check("rd_after_drain", wq.size(), 0);
                end
            end
        end
    end

    // One core request; call at a tick point. rel_after>0 releases the hold after that many cycles.
    task automatic do_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int rel_after, output int lat, output int rdy_n,
                          output logic [DATA_W-1:0] rdata);
        int                occ;
        bit                fwd;
        logic [DATA_W-1:0] exp_d;
        occ   = wq.size() + (just_done ? 1 : 0);
        fwd   = 1'b0;
`ifdef WBUF_FORWARD_EN
        if (!wr) begin
            if (just_done && jd_addr == a) fwd = 1'b1;
            foreach (wq[k]) if (wq[k].addr == a) fwd = 1'b1;
        end
`endif
        exp_d = ref_rd(a);
        if (wr) begin
            wq.push_back('{addr: a, data: d});
            ref_mem[a] = d;
        end
        core_start = 1'b1; core_write = wr; core_addr = a; core_data_wr = d;
        lat = 0; rdy_n = -1;
        forever begin
            tick();
            if (lat == 0) begin
                core_start = 1'b0; core_write = 1'b0;
                core_addr = ADDR_W'($urandom); core_data_wr = $urandom;
            end
            lat++;
            if (rdy_n < 0 && just_done) rdy_n = lat;
            if (core_ready) break;
            if (rel_after > 0 && lat == rel_after) hold = 1'b0;
            if (lat > 400) begin
                check("ready_timeout", core_ready, 1'b1);
                break;
            end
        end
        rdata = core_data_rd;
        if (!wr) check("ld_data", rdata, exp_d);
        if (wr && occ < DEPTH) check("st_lat", lat, 1);
        if (wr && occ >= DEPTH) check("st_pend", lat > 1, 1'b1);
        if (fwd) check("fwd_lat", lat, 1);
        $display("txn %s addr=0x%0h data=0x%0h lat=%0d", wr ? "ST" : "LD", a, wr ? d : rdata, lat);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500 && !wb_empty; i++) tick();
        check("drained", wb_empty, 1'b1);
        check("wq_empty", wq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_ready"}, core_ready, 1'b0);
        check({tag, "_core_data_rd"}, core_data_rd, '0);
        check({tag, "_mem_start"}, mem_start, 1'b0);
        check({tag, "_mem_write"}, mem_write, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, '0);
        check({tag, "_mem_data_wr"}, mem_data_wr, '0);
        check({tag, "_wb_empty"}, wb_empty, 1'b1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached with %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int                lat, rdy_n, rd0, late0;
        logic [DATA_W-1:0] rdata;
        rst = 1'b1; core_start = 1'b0; core_write = 1'b0; core_addr = '0; core_data_wr = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Posted stores with downstream held off, then a fifth store while full.
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            do_req(1'b1, ADDR_W'(32'h10 + i), 32'hA0 + i, 0, lat, rdy_n, rdata);
            check("posted_lat", lat, 1);
        end
        check("busy_not_empty", wb_empty, 1'b0);
        tick();
        do_req(1'b1, 30'h14, 32'hA4, 4, lat, rdy_n, rdata);
        check("full_held", lat > 4, 1'b1);
        check("full_ready_gap", lat - rdy_n, 2);
        wait_drain();

        // Load after store waits for the drain.
        dmem[30'h30] = 32'h1234;
        ref_mem[30'h30] = 32'h1234;
        tick();
        do_req(1'b1, 30'h20, 32'h55, 0, lat, rdy_n, rdata);
        tick();
        do_req(1'b0, 30'h30, '0, 0, lat, rdy_n, rdata);
        check("ld_order_data", rdata, 32'h1234);
        wait_drain();

        // Same-address stores followed by a load of that address.
`ifdef WBUF_FORWARD_EN
        hold = 1'b1;
`endif
        tick();
        do_req(1'b1, 30'h40, 32'h11, 0, lat, rdy_n, rdata);
        tick();
        do_req(1'b1, 30'h40, 32'h22, 0, lat, rdy_n, rdata);
        tick();
        rd0 = rd_issued;
        do_req(1'b0, 30'h40, '0, 0, lat, rdy_n, rdata);
        check("fwd_data", rdata, 32'h22);
`ifdef WBUF_FORWARD_EN
        check("fwd_no_read", rd_issued - rd0, 0);
        hold = 1'b0;
`else
        check("nofwd_read", rd_issued - rd0, 1);
`endif
        wait_drain();

        // Push and pop in the same cycle at count 2; occupancy shows in when the FIFO fills.
        hold = 1'b1;
        tick();
        do_req(1'b1, 30'h60, 32'hB0, 0, lat, rdy_n, rdata);
        tick();
        do_req(1'b1, 30'h61, 32'hB1, 0, lat, rdy_n, rdata);
        tick();
        tick();
        hold = 1'b0;
        tick();
        check("pp_pop_now", just_done, 1'b1);
        hold = 1'b1;
        do_req(1'b1, 30'h62, 32'hB2, 0, lat, rdy_n, rdata);
        check("pp_push_lat", lat, 1);
        tick();
        do_req(1'b1, 30'h63, 32'hB3, 0, lat, rdy_n, rdata);
        tick();
        do_req(1'b1, 30'h64, 32'hB4, 0, lat, rdy_n, rdata);
        tick();
        do_req(1'b1, 30'h65, 32'hB5, 3, lat, rdy_n, rdata);
        check("pp_full_gap", lat - rdy_n, 2);
        wait_drain();

        // Reset while a write waits downstream; its late completion must be ignored.
        hold = 1'b1;
        tick();
        do_req(1'b1, 30'h50, 32'h77, 0, lat, rdy_n, rdata);
        tick();
        do_req(1'b1, 30'h51, 32'h78, 0, lat, rdy_n, rdata);
        tick();
        tick();
        check("rst_mid_drain", mem_write, 1'b1);
        abandon = 1'b1;
        late0   = late_cnt;
        rst     = 1'b1;
        #1;
        check_reset_outputs("rst_drain");
        tick();
        rst  = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_rst_start", mem_start, 1'b0);
            check("post_rst_ready", core_ready, 1'b0);
        end
        check("late_ready_seen", late_cnt - late0, 1);
        check("post_rst_empty", wb_empty, 1'b1);
        wq.delete();
        ref_mem.delete();
        foreach (dmem[k]) ref_mem[k] = dmem[k];

        // Random traffic over a small address set to exercise fullness and reuse.
        lat_max = 6;
        for (int n = 0; n < 250; n++) begin
            logic              wr;
            logic [ADDR_W-1:0] a;
            repeat ($urandom_range(1, 3)) begin
                tick();
                check("idle_ready", core_ready, 1'b0);
            end
            wr = ($urandom_range(0, 99) < 60);
            a  = ADDR_W'(32'h100 + $urandom_range(0, 5));
            do_req(wr, a, $urandom, 0, lat, rdy_n, rdata);
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
